datamem_ws: RTL and testbench

Parametrised, request/response data memory for the pipelined core. It generalises the single-cycle data memory in three ways:
- configurable depth and wait states, with a Req/Ready/Valid handshake;
- sign or zero extension of sub-word loads;
- fault reporting for misaligned, out-of-range and illegal-width accesses.

It sits behind the MEM stage, and the hazard unit stalls the pipeline on Ready/Valid.

---
 rtl/datamem_pkg.sv | 37 +++
 rtl/datamem_ws_if.sv | 26 ++
 rtl/datamem_lane.sv | 43 ++++
 rtl/datamem_ws.sv | 117 +++++++++++
 tb/tb_datamem_ws.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/datamem_pkg.sv
// Shared encodings, state type and access checks
// for the wait-state data memory.
package datamem_pkg;

    localparam logic [1:0] WIDTH_WORD = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b10;
    localparam logic [1:0] WIDTH_BYTE = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef struct packed {
        logic        we;
        logic [1:0]  width;
        logic        lu;
        logic [31:0] a;
    } req_t;

    function automatic logic access_fault(
        input logic [31:0] a,
        input logic [1:0]  width,
        input int unsigned abits
    );
        logic hi;
        hi = (a >> (abits + 2)) != 32'd0;
        unique case (width)
            WIDTH_WORD: access_fault = hi | (a[1:0] != 2'b00);
            WIDTH_HALF: access_fault = hi | a[0];
            WIDTH_BYTE: access_fault = hi;
            default:    access_fault = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/datamem_ws_if.sv
// Request/response bundle between MEM stage
// and the wait-state data memory.
interface datamem_ws_if #(
    parameter int WIDTH = 32
);
    logic             Req;
    logic             WE;
    logic [1:0]       WidthSrc;
    logic             LoadUnsigned;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] WD;
    logic             Ready;
    logic             Valid;
    logic [WIDTH-1:0] RD;
    logic             Fault;

    modport master (
        output Req, WE, WidthSrc, LoadUnsigned, A, WD,
        input  Ready, Valid, RD, Fault
    );

    modport slave (
        input  Req, WE, WidthSrc, LoadUnsigned, A, WD,
        output Ready, Valid, RD, Fault
    );
endinterface

// File: rtl/datamem_lane.sv
// Byte/half/word lane merge for stores and
// lane extract with sign/zero extension for loads.
module datamem_lane
    import datamem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wd,
    input  logic [1:0]  a_lo,
    input  logic [1:0]  width,
    input  logic        lu,
    output logic [31:0] merged,
    output logic [31:0] rdata
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b      = word[{a_lo, 3'b000} +: 8];
        h      = word[{a_lo[1], 4'b0000} +: 16];
        merged = word;
        rdata  = word;
        unique case (width)
            WIDTH_BYTE: begin
                merged[{a_lo, 3'b000} +: 8] = wd[7:0];
                rdata = {{24{b[7] & ~lu}}, b};
            end
            WIDTH_HALF: begin
                merged[{a_lo[1], 4'b0000} +: 16] = wd[15:0];
                rdata = {{16{h[15] & ~lu}}, h};
            end
            WIDTH_WORD: begin
                merged = wd;
                rdata  = word;
            end
            default: begin
                merged = word;
                rdata  = word;
            end
        endcase
    end

endmodule

// File: rtl/datamem_ws.sv
// Data memory with configurable depth, wait states,
// sub-word load extension and access fault reporting.
module datamem_ws
    import datamem_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input logic         clk,
    input logic         reset,
    datamem_ws_if.slave bus
);

    localparam int ABITS = $clog2(DEPTH);
    localparam logic [3:0] WS_INIT =
        (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    (* ram_style = "block" *)
    logic [31:0] mem [DEPTH];

    state_e           state, nxt;
    logic [3:0]       cnt, cnt_nxt;
    req_t             lat, live, cur;
    logic             ready, accept, flt, wr_en;
    logic [ABITS-1:0] idx;
    logic [31:0]      word, merged, ldata;
    logic             valid_q, fault_q;
    logic [WIDTH-1:0] rd_q;

    assign ready  = (state != WAIT);
    assign accept = bus.Req & ready & reset;

    // A request being accepted is served from the live bus so that a
    // zero-wait response can be registered on the accept edge itself.
    always_comb begin
        live = '{we: bus.WE, width: bus.WidthSrc,
                 lu: bus.LoadUnsigned, a: bus.A};
        cur  = accept ? live : lat;
    end

    assign flt   = access_fault(cur.a, cur.width, ABITS);
    assign idx   = cur.a[ABITS+1:2];
    assign word  = mem[idx];
    assign wr_en = accept & cur.we & ~flt;

    datamem_lane u_lane (
        .word   (word),
        .wd     (bus.WD),
        .a_lo   (cur.a[1:0]),
        .width  (cur.width),
        .lu     (cur.lu),
        .merged (merged),
        .rdata  (ldata)
    );

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= merged;
        end
    end

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        unique case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        nxt = RESP;
                    end else begin
                        nxt     = WAIT;
                        cnt_nxt = WS_INIT;
                    end
                end else begin
                    nxt = IDLE;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            lat     <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            rd_q    <= '0;
        end else begin
            state   <= nxt;
            cnt     <= cnt_nxt;
            valid_q <= (nxt == RESP);
            if (accept) begin
                lat <= live;
            end
            if (nxt == RESP) begin
                fault_q <= flt;
                rd_q    <= (flt | cur.we) ? '0 : ldata;
            end
        end
    end

    assign bus.Ready = ready;
    assign bus.Valid = valid_q;
    assign bus.RD    = rd_q;
    assign bus.Fault = fault_q;

endmodule

// File: tb/tb_datamem_ws.sv
// Randomized and directed bench for datamem_ws
// against an arithmetic memory model.
module tb_datamem_ws;

    logic        clk;
    logic        rst;
    logic        dreq, dwe, dlu;
    logic [1:0]  dwidth;
    logic [31:0] da, dwd;
    int          sel;

    logic        ready, valid, fault;
    logic [31:0] rd;

    int nchk;
    int nfail;

    bit [31:0] mdl [3][256];
    int        ws_of [3] = '{2, 0, 3};

    datamem_ws_if #(.WIDTH(32)) b0 ();
    datamem_ws_if #(.WIDTH(32)) b1 ();
    datamem_ws_if #(.WIDTH(32)) b2 ();

    assign b0.Req = dreq && (sel == 0);
    assign b1.Req = dreq && (sel == 1);
    assign b2.Req = dreq && (sel == 2);
    assign b0.WE = dwe;
    assign b1.WE = dwe;
    assign b2.WE = dwe;
    assign b0.WidthSrc = dwidth;
    assign b1.WidthSrc = dwidth;
    assign b2.WidthSrc = dwidth;
    assign b0.LoadUnsigned = dlu;
    assign b1.LoadUnsigned = dlu;
    assign b2.LoadUnsigned = dlu;
    assign b0.A = da;
    assign b1.A = da;
    assign b2.A = da;
    assign b0.WD = dwd;
    assign b1.WD = dwd;
    assign b2.WD = dwd;

    datamem_ws #(.WIDTH(32), .DEPTH(256), .WAIT_STATES(2)) u0 (
        .clk(clk), .reset(rst), .bus(b0));
    datamem_ws #(.WIDTH(32), .DEPTH(256), .WAIT_STATES(0)) u1 (
        .clk(clk), .reset(rst), .bus(b1));
    datamem_ws #(.WIDTH(32), .DEPTH(256), .WAIT_STATES(3)) u2 (
        .clk(clk), .reset(rst), .bus(b2));

    always_comb begin
        ready = b0.Ready; valid = b0.Valid;
        rd    = b0.RD;    fault = b0.Fault;
        if (sel == 1) begin
            ready = b1.Ready; valid = b1.Valid;
            rd    = b1.RD;    fault = b1.Fault;
        end else if (sel == 2) begin
            ready = b2.Ready; valid = b2.Valid;
            rd    = b2.RD;    fault = b2.Fault;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit mfault(input logic [1:0] w,
                                  input logic [31:0] a);
        if (w == 2'b11) return 1'b1;
        if (w == 2'b10 && a % 2 != 0) return 1'b1;
        if (w == 2'b00 && a % 4 != 0) return 1'b1;
        return a >= 32'd1024;
    endfunction

    function automatic logic [31:0] mload(input logic [31:0] wrd,
                                          input logic [1:0] w,
                                          input logic [31:0] a,
                                          input logic lu);
        int unsigned sh;
        logic [31:0] v;
        sh = 8 * (a % 4);
        if (w == 2'b00) return wrd;
        if (w == 2'b01) begin
            v = (wrd >> sh) & 32'hFF;
            if (!lu && v >= 32'd128) v = v + 32'hFFFFFF00;
        end else begin
            v = (wrd >> sh) & 32'hFFFF;
            if (!lu && v >= 32'd32768) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] mstore(input logic [31:0] old,
                                           input logic [31:0] wdat,
                                           input logic [1:0] w,
                                           input logic [31:0] a);
        int unsigned sh;
        logic [31:0] mask;
        sh = 8 * (a % 4);
        if (w == 2'b00) return wdat;
        mask = ((w == 2'b01) ? 32'hFF : 32'hFFFF) << sh;
        return (old & ~mask) | ((wdat << sh) & mask);
    endfunction

    task automatic access(input logic w_e, input logic [1:0] w,
                          input logic l_u, input logic [31:0] a_i,
                          input logic [31:0] wd_i,
                          output logic [31:0] got);
        logic [31:0] exp_rd;
        bit f;
        int k;
        int wi;
        f  = mfault(w, a_i);
        wi = int'(a_i / 4) % 256;
        if (w_e && !f) mdl[sel][wi] = mstore(mdl[sel][wi], wd_i, w, a_i);
        exp_rd = (f || w_e) ? 32'd0 : mload(mdl[sel][wi], w, a_i, l_u);
        @(negedge clk);
        dreq = 1'b1; dwe = w_e; dwidth = w; dlu = l_u;
        da = a_i; dwd = wd_i;
        chk("ready_idle", {31'd0, ready}, 32'd1);
        @(posedge clk);
        #1;
        dreq = 1'b0; dwe = $urandom_range(0, 1);
        da = $urandom; dwd = $urandom; dwidth = 2'($urandom);
        k = 0;
        @(negedge clk);
        while (!valid && k < 40) begin
            chk("ready_wait", {31'd0, ready}, 32'd0);
            k++;
            @(negedge clk);
        end
        chk("latency", k, ws_of[sel]);
        chk("fault", {31'd0, fault}, {31'd0, f});
        chk("rd", rd, exp_rd);
        got = rd;
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] v;
        logic [1:0]  w;
        logic [31:0] a;
        nchk = 0; nfail = 0; sel = 0;
        dreq = 1'b0; dwe = 1'b0; dlu = 1'b0;
        dwidth = 2'b00; da = '0; dwd = '0;

        // reset with a request pending: it must be ignored
        rst = 1'b0;
        repeat (2) @(negedge clk);
        dreq = 1'b1; dwe = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_rd", rd, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        dreq = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_valid2", {31'd0, valid}, 32'd0);

        // word round trip
        sel = 0;
        access(1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, got);
        access(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, got);
        chk("word_rt", got, 32'hDEADBEEF);

        // extension
        access(1'b1, 2'b00, 1'b0, 32'h20, 32'h80F07F01, got);
        access(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, got);
        chk("lb_s", got, 32'hFFFFFFF0);
        access(1'b0, 2'b01, 1'b1, 32'h23, 32'h0, got);
        chk("lbu", got, 32'h00000080);
        access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, got);
        chk("lh_s0", got, 32'h00007F01);
        access(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, got);
        chk("lh_s2", got, 32'hFFFF80F0);

        // partial stores
        access(1'b1, 2'b00, 1'b0, 32'h30, 32'h0, got);
        access(1'b1, 2'b01, 1'b0, 32'h31, 32'hFFFFFFAB, got);
        access(1'b1, 2'b10, 1'b0, 32'h32, 32'hFFFF1234, got);
        access(1'b0, 2'b00, 1'b0, 32'h30, 32'h0, got);
        chk("partial", got, 32'h1234AB00);

        // faults leave memory unchanged
        access(1'b1, 2'b00, 1'b0, 32'h00, 32'h0BADF00D, got);
        access(1'b1, 2'b00, 1'b0, 32'h02, 32'h11111111, got);
        access(1'b1, 2'b10, 1'b0, 32'h01, 32'h22222222, got);
        access(1'b1, 2'b11, 1'b0, 32'h00, 32'h33333333, got);
        access(1'b1, 2'b00, 1'b0, 32'h400, 32'h44444444, got);
        access(1'b0, 2'b11, 1'b0, 32'h00, 32'h0, got);
        chk("flt_ld_rd", got, 32'h0);
        access(1'b0, 2'b00, 1'b0, 32'h00, 32'h0, got);
        chk("flt_mem", got, 32'h0BADF00D);

        // back-to-back store then load, zero wait states
        sel = 1;
        mdl[1][17] = 32'hC0FFEE42;
        @(negedge clk);
        dreq = 1'b1; dwe = 1'b1; dwidth = 2'b00;
        da = 32'h44; dwd = 32'hC0FFEE42;
        @(posedge clk);
        #1;
        dwe = 1'b0; dwd = 32'h0;
        @(negedge clk);
        chk("b2b_v0", {31'd0, valid}, 32'd1);
        chk("b2b_r0", {31'd0, ready}, 32'd1);
        chk("b2b_rd0", rd, 32'd0);
        @(posedge clk);
        #1;
        dreq = 1'b0;
        @(negedge clk);
        chk("b2b_v1", {31'd0, valid}, 32'd1);
        chk("b2b_r1", {31'd0, ready}, 32'd1);
        chk("b2b_rd1", rd, 32'hC0FFEE42);
        @(negedge clk);
        chk("b2b_v2", {31'd0, valid}, 32'd0);

        // randomized traffic on the WS=2 and WS=0 instances
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int i = 0; i < 16; i++)
                access(1'b1, 2'b00, 1'b0, 32'(i * 4), $urandom, got);
            for (int i = 0; i < 120; i++) begin
                w = 2'($urandom);
                a = $urandom_range(0, 63);
                if ($urandom_range(0, 9) == 0)
                    a = a | (32'd1 << $urandom_range(10, 31));
                access(1'($urandom), w, 1'($urandom), a, $urandom, got);
            end
        end

        // reset in the middle of a wait
        sel = 2;
        access(1'b1, 2'b00, 1'b0, 32'h40, 32'h5A5A1234, got);
        access(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, got);
        chk("ws3_ld", got, 32'h5A5A1234);
        @(negedge clk);
        dreq = 1'b1; dwe = 1'b0; dwidth = 2'b00; da = 32'h40;
        @(posedge clk);
        #1;
        dreq = 1'b0;
        @(negedge clk);
        chk("mid_wait", {31'd0, ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mid_rd", rd, 32'd0);
        chk("mid_fault", {31'd0, fault}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("mid_valid", {31'd0, valid}, 32'd0);
            chk("mid_ready", {31'd0, ready}, 32'd1);
            @(negedge clk);
        end
        access(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, got);
        chk("mid_mem", got, 32'h5A5A1234);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
